alu_issue: RTL
==============

Name: alu_issue

Overview:
- Decode/issue stage feeding the ALU; the producer side of the ALU's operand_1/operand_2/func3/func7 interface.
- Accepts 32-bit RV32I instructions over a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011).
- Reads rs1/rs2 from the register file, builds operands and ALU op fields, and holds them in a one-entry output register.
- A 32-bit busy scoreboard blocks RAW/WAW hazards until writeback.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count. The scoreboard is NREGS bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  discard the output register contents.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  instruction accepted this cycle.
- instr  in  32  instruction word.
- rs1_addr  out  5  register file read address 1 (instr[19:15], combinational).
- rs2_addr  out  5  register file read address 2 (instr[24:20], combinational).
- rs1_data  in  XLEN  register file read data 1 (combinational return).
- rs2_data  in  XLEN  register file read data 2 (combinational return).
- issue_valid  out  1  output register holds an op.
- issue_ready  in  1  ALU/execute accepts.
- operand_1  out  XLEN  rs1 value.
- operand_2  out  XLEN  rs2 value, sign-extended imm, or zero-extended shamt.
- alu_op  out  3  func3.
- alu_op2  out  7  func7.
- rd  out  5  destination register.
- illegal  out  1  unsupported encoding.
- wb_valid  in  1  writeback completes.
- wb_rd  in  5  writeback register.

Behaviour:
- Reset: issue_valid=0, operand_1=0, operand_2=0, alu_op=0, alu_op2=0, rd=0, illegal=0, scoreboard all 0. instr_ready=0 while rst=1.
- Capture condition: instr_valid && instr_ready. Operands and fields are registered at that edge, so latency is 1 cycle from capture to issue_valid=1.
- instr_ready = !rst && !flush && !hazard && (!issue_valid || issue_ready).
- hazard is true when any of these holds:
  - busy[rs1];
  - busy[rs2], for R-type only;
  - busy[rd], i.e. WAW;
  - issue_valid && rd_q!=0 && rd_q equals rs1, rs2 (R-type only) or rd of the incoming instruction.
- x0 never hazards.
- Busy uses registered state only: a wb_valid arriving in cycle N unblocks the dependent instruction in cycle N+1. There is no bypass.
- Scoreboard set/clear:
  - Set busy[rd_q] on the output handshake (issue_valid && issue_ready) when rd_q!=0 and illegal=0.
  - Clear busy[wb_rd] on wb_valid.
  - If set and clear hit the same index in the same cycle, set wins.
  - busy[0] is always 0.
- R-type decode:
  - func7=0000000 is legal for every func3.
  - func7=0100000 is legal only for func3 000 (SUB) and 101 (SRA).
  - Any other func7 is illegal.
- I-type decode:
  - operand_2 = sign-extended instr[31:20].
  - alu_op2 = 0000000 for func3 000/010/011/100/110/111, so ADDI is never decoded as SUB.
  - func3 001: imm[11:5] must be 0000000.
  - func3 101: imm[11:5] must be 0000000 or 0100000, and that value goes to alu_op2.
  - For func3 001 and 101, operand_2 = zero-extended shamt instr[24:20].
- Any other opcode is illegal.
- Output hold: while issue_valid && !issue_ready, all outputs stay stable.
- Back-to-back: capture is allowed in the same cycle as the output handshake.
- flush:
  - issue_valid goes to 0 at the next edge; no busy bit is set for the discarded op.
  - instr_ready is 0 that cycle.
  - The scoreboard is untouched, so in-flight writebacks still clear their bits.
- Reset mid-operation: all state returns to reset values at the next edge. Any handshake in that cycle is void.

Optional Feature:
- Macro ALU_ISSUE_ILLEGAL_TRAP_EN.
- Defined: illegal instructions are captured and issued with illegal=1, operand_1=0, operand_2=0, alu_op=000, alu_op2=0000000, rd=0. No busy bit is set.
- Undefined: the illegal output is tied to 0. Illegal instructions are accepted (instr_ready as normal) and dropped, and issue_valid is not set for them.

Decomposition:
- Package kantv_isa_pkg holds:
  - OPC_OP=7'b0110011 and OPC_OP_IMM=7'b0010011;
  - F7_BASE=7'b0000000 and F7_ALT=7'b0100000;
  - func3 constants (F3_ADD through F3_AND);
  - an issue_t struct {operand_1, operand_2, alu_op, alu_op2, rd, illegal}.
- Sub-module alu_scoreboard: NREGS busy bits, one set port, one clear port, two read ports plus an rd read port. This is the natural split.
- Decode stays inline.

Test Plan:
- After reset, ADD x3,x1,x2 with rs1_data=5, rs2_data=7 -> next cycle issue_valid=1, operand_1=5, operand_2=7, alu_op=000, alu_op2=0000000, rd=3.
- ADDI x4,x1,-1 (imm 0xFFF) -> operand_2=0xFFFFFFFF, alu_op2=0000000. SRAI x5,x1,4 -> operand_2=4, alu_op2=0100000.
- Issue ADD x3 (handshake), then ADD x6,x3,x0 -> instr_ready=0 until the cycle after wb_valid=1 with wb_rd=3, then accepted.
- Hold issue_ready=0 for 3 cycles with a second instr_valid pending -> outputs stable, instr_ready=0; on issue_ready=1 the handshake and next capture happen in the same cycle.
- func7=0100000 with func3=001 -> with TRAP_EN, illegal=1, rd=0, no busy set; without it, no issue_valid and the next instruction proceeds.
- flush while issue_valid=1 for ADD x7 -> issue_valid=0 next cycle, busy[7] stays 0, and a following ADD x8,x7,x0 is accepted immediately.

Source files
------------

// File: rtl/kantv_isa_pkg.sv
// kantv_isa_pkg: RV32I OP/OP-IMM encodings and the issue register record shared by the decode/issue stage.
package kantv_isa_pkg;
    localparam int ISA_XLEN = 32;
    localparam logic [6:0] OPC_OP = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    typedef struct packed {
        logic [ISA_XLEN-1:0] operand_1;
        logic [ISA_XLEN-1:0] operand_2;
        logic [2:0]          alu_op;
        logic [6:0]          alu_op2;
        logic [4:0]          rd;
        logic                illegal;
    } issue_t;
endpackage

// File: rtl/alu_scoreboard.sv
// alu_scoreboard: per-register busy bits between issue and writeback; set beats clear, x0 never busy.
module alu_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_idx,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_idx,
    input  logic [AW-1:0] rs1_idx,
    input  logic [AW-1:0] rs2_idx,
    input  logic [AW-1:0] rd_idx,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy
);
    logic [NREGS-1:0] busy, busy_nxt;
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else busy <= busy_nxt;
    end
    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];
    assign rd_busy = busy[rd_idx];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I OP/OP-IMM decode and one-entry issue register with a busy scoreboard for RAW/WAW.
// ALU_ISSUE_ILLEGAL_TRAP_EN: issue illegal encodings as zeroed ops flagged illegal instead of dropping them.
module alu_issue
    import kantv_isa_pkg::*;
#(
    parameter int XLEN = ISA_XLEN,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [XLEN-1:0] operand_1,
    output logic [XLEN-1:0] operand_2,
    output logic [2:0]      alu_op,
    output logic [6:0]      alu_op2,
    output logic [4:0]      rd,
    output logic            illegal,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd
);
    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd_in;
    logic is_r, is_i, shift_i, r_ok, i_ok, illegal_in;
    logic rs1_busy, rs2_busy, rd_busy, hazard, cap, take, set_en;
    issue_t d, q;

    assign opcode = instr[6:0];
    assign rd_in = instr[11:7];
    assign f3 = instr[14:12];
    assign rs1_addr = instr[19:15];
    assign rs2_addr = instr[24:20];
    assign f7 = instr[31:25];

    assign is_r = opcode == OPC_OP;
    assign is_i = opcode == OPC_OP_IMM;
    assign shift_i = f3 == F3_SLL || f3 == F3_SRL;
    assign r_ok = f7 == F7_BASE || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SRL));
    assign i_ok = f3 == F3_SLL ? f7 == F7_BASE :
                  f3 == F3_SRL ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
    assign illegal_in = !((is_r && r_ok) || (is_i && i_ok));

    // Illegal ops carry nothing but the flag so the ALU never sees stray operands.
    always_comb begin
        d = '0;
        d.illegal = illegal_in;
        if (!illegal_in) begin
            d.operand_1 = rs1_data;
            d.operand_2 = is_r ? rs2_data :
                          shift_i ? {{(XLEN-5){1'b0}}, instr[24:20]} : {{(XLEN-12){instr[31]}}, instr[31:20]};
            d.alu_op = f3;
            d.alu_op2 = (is_r || f3 == F3_SRL) ? f7 : F7_BASE;
            d.rd = rd_in;
        end
    end

    // The op sitting in the output register has not reached the scoreboard yet, so compare against it too.
    assign hazard = rs1_busy || (is_r && rs2_busy) || rd_busy ||
                    (issue_valid && q.rd != 5'd0 &&
                     (q.rd == rs1_addr || (is_r && q.rd == rs2_addr) || q.rd == rd_in));
    assign instr_ready = !rst && !flush && !hazard && (!issue_valid || issue_ready);
    assign cap = instr_valid && instr_ready;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    assign take = cap;
    assign illegal = q.illegal;
`else
    assign take = cap && !illegal_in;
    assign illegal = 1'b0;
`endif
    assign set_en = issue_valid && issue_ready && !flush && q.rd != 5'd0 && !q.illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid <= 1'b0;
            q <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (cap) begin
            issue_valid <= take;
            if (take) q <= d;
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

    assign operand_1 = q.operand_1;
    assign operand_2 = q.operand_2;
    assign alu_op = q.alu_op;
    assign alu_op2 = q.alu_op2;
    assign rd = q.rd;

    alu_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk(clk),
        .rst(rst),
        .set_en(set_en),
        .set_idx(q.rd),
        .clr_en(wb_valid),
        .clr_idx(wb_rd),
        .rs1_idx(rs1_addr),
        .rs2_idx(rs2_addr),
        .rd_idx(rd_in),
        .rs1_busy(rs1_busy),
        .rs2_busy(rs2_busy),
        .rd_busy(rd_busy)
    );
endmodule
